// File: rtl/titan_bus_pkg.sv
// Shared opcode constants, FSM state encoding and index-width helper for the core bus bridge.
package titan_bus_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_STREAM = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_WAIT = 2'd1,
    ST_STREAM   = 2'd2
  } bridge_state_t;

  // Width of an index into a bank of n registers; a single-entry bank still gets one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/titan_addr_decode.sv
// Window decoder: turns a bus address into a hit flag plus an input or output register index.
// All comparisons are done on a 64-bit widened address so the window never aliases at its end
// or at the top of the address space.
module titan_addr_decode
  import titan_bus_pkg::*;
#(
  parameter int unsigned TOTAL_INPUTS  = 2,
  parameter int unsigned TOTAL_OUTPUTS = 1,
  parameter int unsigned START_ADDRESS = 0,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 24
) (
  input  logic [ADDR_WIDTH-1:0]              i_address,
  output logic                               o_hit,
  output logic                               o_is_input,
  output logic [idxWidth(TOTAL_INPUTS)-1:0]  o_in_index,
  output logic [idxWidth(TOTAL_OUTPUTS)-1:0] o_out_index
);

  localparam int unsigned IN_W  = idxWidth(TOTAL_INPUTS);
  localparam int unsigned OUT_W = idxWidth(TOTAL_OUTPUTS);

  localparam logic [63:0] START64 = 64'(START_ADDRESS);
  localparam logic [63:0] END64   = START64 + 64'(TOTAL_INPUTS) + 64'(TOTAL_OUTPUTS);
  localparam logic [63:0] SPACE64 = 64'd1 << ADDR_WIDTH;

  // Refuse to build a bridge with an empty bank, zero-width data or a window past the address space.
  if (TOTAL_INPUTS == 0 || TOTAL_OUTPUTS == 0 || DATA_WIDTH == 0 || END64 > SPACE64) begin : g_bad_params
    $error("titan_addr_decode: illegal parameter set");
  end

  logic [63:0] w_addr64;

  // Compare the widened address against the window and derive per-bank register indices.
  always_comb begin
    w_addr64    = 64'(i_address);
    o_hit       = (w_addr64 >= START64) && (w_addr64 < END64);
    o_is_input  = o_hit && ((w_addr64 - START64) < 64'(TOTAL_INPUTS));
    o_in_index  = IN_W'(w_addr64 - START64);
    o_out_index = OUT_W'(w_addr64 - START64 - 64'(TOTAL_INPUTS));
  end

endmodule

// File: rtl/core_bus_bridge.sv
// Bus bridge between an opcode-driven bus and a compute core: input registers feed the core,
// output registers capture its results on completion and can be read back or streamed out.
module core_bus_bridge
  import titan_bus_pkg::*;
#(
  parameter int unsigned TOTAL_INPUTS  = 2,
  parameter int unsigned TOTAL_OUTPUTS = 1,
  parameter int unsigned START_ADDRESS = 0,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 24
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [7:0]                          instruction_i,
  input  logic [ADDR_WIDTH-1:0]               address_i,
  input  logic [DATA_WIDTH-1:0]               value_i,
  output logic [DATA_WIDTH-1:0]               result_o,
  output logic [DATA_WIDTH-1:0]               stream_o,
  output logic                                stream_valid_o,
  output logic                                stream_last_o,
  output logic [TOTAL_INPUTS*DATA_WIDTH-1:0]  core_inputs_o,
  input  logic [TOTAL_OUTPUTS*DATA_WIDTH-1:0] core_outputs_i,
  output logic                                core_start_o,
  input  logic                                core_done_i,
  output logic                                busy_o,
  output logic                                hit_o
);

  localparam int unsigned IN_W  = idxWidth(TOTAL_INPUTS);
  localparam int unsigned OUT_W = idxWidth(TOTAL_OUTPUTS);

  logic [DATA_WIDTH-1:0] r_in_regs  [TOTAL_INPUTS];
  logic [DATA_WIDTH-1:0] r_out_regs [TOTAL_OUTPUTS];
  bridge_state_t         r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_hit;
  logic                  r_start;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_stream;
  logic                  r_stream_valid;
  logic                  r_stream_last;
  logic [OUT_W-1:0]      r_stream_idx;

  logic                  w_hit;
  logic                  w_is_input;
  logic [IN_W-1:0]       w_in_index;
  logic [OUT_W-1:0]      w_out_index;
  logic                  w_known_op;
  logic [DATA_WIDTH-1:0] w_read_data;

  titan_addr_decode #(
    .TOTAL_INPUTS  (TOTAL_INPUTS),
    .TOTAL_OUTPUTS (TOTAL_OUTPUTS),
    .START_ADDRESS (START_ADDRESS),
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_decode (
    .i_address   (address_i),
    .o_hit       (w_hit),
    .o_is_input  (w_is_input),
    .o_in_index  (w_in_index),
    .o_out_index (w_out_index)
  );

  // Pick the addressed register for READ and flag opcodes that count as real instructions.
  always_comb begin
    w_known_op  = (instruction_i != OP_NOP) && (instruction_i <= OP_STREAM);
    w_read_data = r_out_regs[w_out_index];
    if (w_is_input) begin
      w_read_data = r_in_regs[w_in_index];
    end
  end

  // Input registers, READ result and hit flag; writes are locked out while the FSM is busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TOTAL_INPUTS; i++) begin
        r_in_regs[i] <= '0;
      end
      r_result <= '0;
      r_hit    <= 1'b0;
    end else begin
      if (w_known_op) begin
        r_hit <= w_hit;
      end
      if (instruction_i == OP_READ && w_hit) begin
        r_result <= w_read_data;
      end
      if (instruction_i == OP_WRITE && w_is_input && r_state == ST_IDLE) begin
        r_in_regs[w_in_index] <= value_i;
      end
    end
  end

  // Control FSM: launches the core, captures its results and streams the output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_stream       <= '0;
      r_stream_valid <= 1'b0;
      r_stream_last  <= 1'b0;
      r_stream_idx   <= '0;
      for (int j = 0; j < TOTAL_OUTPUTS; j++) begin
        r_out_regs[j] <= '0;
      end
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instruction_i == OP_RUN) begin
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN_WAIT;
          end else if (instruction_i == OP_STREAM) begin
            r_stream       <= r_out_regs[0];
            r_stream_valid <= 1'b1;
            r_stream_last  <= (TOTAL_OUTPUTS == 1);
            r_stream_idx   <= OUT_W'(1);
            r_busy         <= 1'b1;
            r_state        <= ST_STREAM;
          end
        end
        ST_RUN_WAIT: begin
          if (core_done_i) begin
            for (int j = 0; j < TOTAL_OUTPUTS; j++) begin
              r_out_regs[j] <= core_outputs_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (r_stream_last) begin
            r_stream       <= '0;
            r_stream_valid <= 1'b0;
            r_stream_last  <= 1'b0;
            r_stream_idx   <= '0;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end else begin
            r_stream      <= r_out_regs[r_stream_idx];
            r_stream_last <= (r_stream_idx == OUT_W'(TOTAL_OUTPUTS - 1));
            r_stream_idx  <= r_stream_idx + OUT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Flatten the input register bank onto the core bus, index 0 in the least significant word.
  for (genvar g = 0; g < TOTAL_INPUTS; g++) begin : g_core_in
    assign core_inputs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_in_regs[g];
  end

  assign result_o       = r_result;
  assign stream_o       = r_stream;
  assign stream_valid_o = r_stream_valid;
  assign stream_last_o  = r_stream_last;
  assign core_start_o   = r_start;
  assign busy_o         = r_busy;
  assign hit_o          = r_hit;

endmodule

// File: tb/tb_core_bus_bridge.sv
// Self-checking bench for core_bus_bridge: a default-parameter instance driven with directed
// sequences, and a three-output instance at the top of an 8-bit address space driven with
// directed and random traffic against a cycle-level behavioural model.
module tb_core_bus_bridge;
  import titan_bus_pkg::*;

  localparam int B_START = 251;
  localparam int B_NIN   = 2;
  localparam int B_NOUT  = 3;

  logic clk = 1'b0;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Instance A: default parameters.
  logic        aRst = 1'b1;
  logic [7:0]  aInstr = '0;
  logic [23:0] aAddr = '0;
  logic [31:0] aValue = '0;
  logic [31:0] aCoreOut = '0;
  logic        aDone = 1'b0;
  logic [31:0] aResult, aStream;
  logic        aValid, aLast, aStart, aBusy, aHit;
  logic [63:0] aCoreIn;

  core_bus_bridge u_dutA (
    .clk_i(clk), .rst_i(aRst), .instruction_i(aInstr), .address_i(aAddr), .value_i(aValue),
    .result_o(aResult), .stream_o(aStream), .stream_valid_o(aValid), .stream_last_o(aLast),
    .core_inputs_o(aCoreIn), .core_outputs_i(aCoreOut), .core_start_o(aStart),
    .core_done_i(aDone), .busy_o(aBusy), .hit_o(aHit)
  );

  // Instance B: three outputs, window ends exactly at the top of an 8-bit address space.
  logic        bRst = 1'b1;
  logic [7:0]  bInstr = '0;
  logic [7:0]  bAddr = '0;
  logic [31:0] bValue = '0;
  logic [95:0] bCoreOut = '0;
  logic        bDone = 1'b0;
  logic [31:0] bResult, bStream;
  logic        bValid, bLast, bStart, bBusy, bHit;
  logic [63:0] bCoreIn;

  core_bus_bridge #(
    .TOTAL_INPUTS(B_NIN), .TOTAL_OUTPUTS(B_NOUT), .START_ADDRESS(B_START),
    .DATA_WIDTH(32), .ADDR_WIDTH(8)
  ) u_dutB (
    .clk_i(clk), .rst_i(bRst), .instruction_i(bInstr), .address_i(bAddr), .value_i(bValue),
    .result_o(bResult), .stream_o(bStream), .stream_valid_o(bValid), .stream_last_o(bLast),
    .core_inputs_o(bCoreIn), .core_outputs_i(bCoreOut), .core_start_o(bStart),
    .core_done_i(bDone), .busy_o(bBusy), .hit_o(bHit)
  );

  // Reference model state for instance B (mode 0 idle, 1 waiting for core, 2 streaming).
  logic [31:0] mIn [B_NIN];
  logic [31:0] mOut [B_NOUT];
  logic [31:0] mQ [$];
  logic [31:0] mResult, mStream;
  logic        mHit, mStart, mValid, mLast;
  int          mMode;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one instruction into instance A and return just after the edge that consumes it.
  task automatic applyStimulus(input logic [7:0] instr, input logic [23:0] addr, input logic [31:0] value,
                               input logic done, input logic [31:0] coreOut, input logic rst);
    @(negedge clk);
    aInstr = instr; aAddr = addr; aValue = value; aDone = done; aCoreOut = coreOut; aRst = rst;
    @(posedge clk);
    #1;
    aInstr = OP_NOP; aDone = 1'b0; aRst = 1'b0;
  endtask

  task automatic popStream();
    mStream = mQ.pop_front();
    mValid  = 1'b1;
    mLast   = (mQ.size() == 0);
  endtask

  // Advance the model by one clock using the inputs instance B is about to sample.
  task automatic modelStep(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] value,
                           input logic done, input logic [95:0] coreOut, input logic rst);
    int  off;
    bit  inWin;
    if (rst) begin
      foreach (mIn[i]) mIn[i] = '0;
      foreach (mOut[j]) mOut[j] = '0;
      mQ.delete();
      mResult = '0; mStream = '0; mHit = 0; mStart = 0; mValid = 0; mLast = 0; mMode = 0;
      return;
    end
    off   = int'(addr) - B_START;
    inWin = (int'(addr) >= B_START) && (int'(addr) < B_START + B_NIN + B_NOUT);
    if (op >= 8'd1 && op <= 8'd4) mHit = inWin;
    if (op == OP_READ && inWin) mResult = (off < B_NIN) ? mIn[off] : mOut[off - B_NIN];
    if (op == OP_WRITE && mMode == 0 && inWin && off < B_NIN) mIn[off] = value;
    mStart = 1'b0;
    if (mMode == 0) begin
      if (op == OP_RUN) begin
        mStart = 1'b1;
        mMode  = 1;
      end else if (op == OP_STREAM) begin
        mQ = {mOut[0], mOut[1], mOut[2]};
        popStream();
        mMode = 2;
      end
    end else if (mMode == 1) begin
      if (done) begin
        for (int j = 0; j < B_NOUT; j++) mOut[j] = coreOut[j*32 +: 32];
        mMode = 0;
      end
    end else begin
      if (mQ.size() == 0) begin
        mMode = 0; mValid = 0; mLast = 0;
      end else begin
        popStream();
      end
    end
  endtask

  task automatic compareB();
    checkOutput("B result_o", bResult, mResult);
    checkOutput("B hit_o", bHit, mHit);
    checkOutput("B busy_o", bBusy, mMode != 0);
    checkOutput("B core_start_o", bStart, mStart);
    checkOutput("B stream_valid_o", bValid, mValid);
    checkOutput("B stream_last_o", bLast, mLast);
    checkOutput("B core_inputs_o", bCoreIn, {mIn[1], mIn[0]});
    if (mValid) checkOutput("B stream_o", bStream, mStream);
  endtask

  // Drive one cycle into instance B, step the model, and compare just after the edge.
  task automatic bCycle(input logic [7:0] instr, input logic [7:0] addr, input logic [31:0] value,
                        input logic done, input logic [95:0] coreOut, input logic rst);
    @(negedge clk);
    bInstr = instr; bAddr = addr; bValue = value; bDone = done; bCoreOut = coreOut; bRst = rst;
    modelStep(instr, addr, value, done, coreOut, rst);
    @(posedge clk);
    #1;
    compareB();
  endtask

  // Abort guard in case the run never reaches the summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed checks on A, directed then random checks on B, then the summary.
  initial begin
    logic [7:0]  rOp;
    logic [7:0]  rAddr;

    // Reset with a coincident WRITE that must be discarded.
    applyStimulus(OP_WRITE, 24'd0, 32'h55, 1'b0, 32'h0, 1'b1);
    checkOutput("A reset result_o", aResult, 0);
    checkOutput("A reset hit_o", aHit, 0);
    checkOutput("A reset busy_o", aBusy, 0);
    checkOutput("A reset core_start_o", aStart, 0);
    checkOutput("A reset stream_valid_o", aValid, 0);
    checkOutput("A reset stream_last_o", aLast, 0);
    checkOutput("A reset stream_o", aStream, 0);
    checkOutput("A reset core_inputs_o", aCoreIn, 0);

    applyStimulus(OP_WRITE, 24'd0, 32'h5, 1'b0, 32'h0, 1'b0);
    applyStimulus(OP_WRITE, 24'd1, 32'h7, 1'b0, 32'h0, 1'b0);
    applyStimulus(OP_READ, 24'd1, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A read @1", aResult, 32'h7);
    checkOutput("A hit after read @1", aHit, 1);
    checkOutput("A core_inputs after writes", aCoreIn, 64'h00000007_00000005);
    applyStimulus(OP_READ, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A read @0", aResult, 32'h5);

    applyStimulus(OP_RUN, 24'h123456, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A run start pulse", aStart, 1);
    checkOutput("A run busy", aBusy, 1);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A start pulse ends", aStart, 0);
    checkOutput("A still busy", aBusy, 1);
    applyStimulus(OP_WRITE, 24'd0, 32'h99, 1'b0, 32'h0, 1'b0);
    checkOutput("A write ignored while busy", aCoreIn, 64'h00000007_00000005);
    applyStimulus(OP_READ, 24'd1, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A read served while busy", aResult, 32'h7);
    applyStimulus(OP_RUN, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A run ignored while busy", aStart, 0);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b1, 32'hC, 1'b0);
    checkOutput("A busy cleared on done", aBusy, 0);
    applyStimulus(OP_READ, 24'd2, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A read output @2", aResult, 32'hC);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b1, 32'h77, 1'b0);
    applyStimulus(OP_READ, 24'd2, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A done ignored in idle", aResult, 32'hC);

    applyStimulus(OP_WRITE, 24'd3, 32'h1234, 1'b0, 32'h0, 1'b0);
    checkOutput("A hit after miss write", aHit, 0);
    checkOutput("A miss write no change", aCoreIn, 64'h00000007_00000005);
    checkOutput("A result kept after miss", aResult, 32'hC);
    applyStimulus(OP_WRITE, 24'd2, 32'h1234, 1'b0, 32'h0, 1'b0);
    checkOutput("A hit after output write", aHit, 1);
    applyStimulus(OP_READ, 24'd2, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A output not writable", aResult, 32'hC);
    applyStimulus(OP_READ, 24'hFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A hit top address", aHit, 0);
    checkOutput("A result kept on miss read", aResult, 32'hC);
    applyStimulus(OP_READ, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(8'h7F, 24'd3, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A hit held on unknown opcode", aHit, 1);

    applyStimulus(OP_STREAM, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A stream word", aStream, 32'hC);
    checkOutput("A stream valid", aValid, 1);
    checkOutput("A stream last", aLast, 1);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A stream done", aValid, 0);
    checkOutput("A idle after stream", aBusy, 0);

    applyStimulus(OP_RUN, 24'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("A reset in run_wait busy", aBusy, 0);
    checkOutput("A reset in run_wait result", aResult, 0);
    checkOutput("A reset in run_wait inputs", aCoreIn, 0);
    checkOutput("A reset in run_wait hit", aHit, 0);
    applyStimulus(OP_NOP, 24'd0, 32'h0, 1'b1, 32'h55, 1'b0);
    applyStimulus(OP_READ, 24'd2, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("A done ignored after reset", aResult, 0);

    // Instance B: capture three words, stream twice, then reset mid-stream.
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b0, 96'h0, 1'b1);
    bCycle(OP_RUN, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b1, {32'hC, 32'hB, 32'hA}, 1'b0);
    bCycle(OP_STREAM, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B stream word 0", bStream, 32'hA);
    checkOutput("B no last on word 0", bLast, 0);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B stream word 1", bStream, 32'hB);
    bCycle(OP_READ, 8'd255, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B stream word 2", bStream, 32'hC);
    checkOutput("B last on word 2", bLast, 1);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B read @255 during stream", bResult, 32'hC);
    bCycle(OP_STREAM, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B restream word 0", bStream, 32'hA);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b0, 96'h0, 1'b1);
    checkOutput("B reset mid-stream valid", bValid, 0);
    checkOutput("B reset mid-stream stream_o", bStream, 0);
    bCycle(OP_NOP, 8'd0, 32'h0, 1'b1, {96{1'b1}}, 1'b0);
    bCycle(OP_READ, 8'd253, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B done ignored after reset", bResult, 0);
    bCycle(OP_READ, 8'd0, 32'h0, 1'b0, 96'h0, 1'b0);
    checkOutput("B no alias at wrap", bHit, 0);

    // Random traffic around the window edges against the model.
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rOp = OP_NOP;
        2, 3:    rOp = OP_WRITE;
        4, 5:    rOp = OP_READ;
        6:       rOp = OP_RUN;
        7:       rOp = OP_STREAM;
        8:       rOp = 8'($urandom_range(5, 255));
        default: rOp = OP_READ;
      endcase
      rAddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(246, 255));
      bCycle(rOp, rAddr, $urandom, $urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom},
             $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/core_bus_bridge.md
CORE_BUS_BRIDGE -- requirements
Module: core_bus_bridge

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): TOTAL_INPUTS, 2, core input registers; TOTAL_OUTPUTS, 1, core output registers; START_ADDRESS, 0, first mapped address; DATA_WIDTH, 32, register width; ADDR_WIDTH, 24, bus address width.
REQ-002 clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 instruction_i  in  8  opcode, valid for one cycle when non-zero.
REQ-005 address_i  in  ADDR_WIDTH  target address, sampled with instruction_i.
REQ-006 value_i  in  DATA_WIDTH  write data, sampled with instruction_i.
REQ-007 result_o  out  DATA_WIDTH  registered READ data.
REQ-008 stream_o, stream_valid_o, stream_last_o  out  DATA_WIDTH/1/1  output-register stream.
REQ-009 core_inputs_o  out  TOTAL_INPUTS*DATA_WIDTH  input registers, index 0 in LSBs.
REQ-010 core_outputs_i  in  TOTAL_OUTPUTS*DATA_WIDTH  core results, index 0 in LSBs.
REQ-011 core_start_o  out  1  one-cycle run pulse; core_done_i  in  1  core completion pulse.
REQ-012 busy_o, hit_o  out  1/1  FSM not IDLE; last instruction decoded to this window.

Function
REQ-013 Map: input i at START_ADDRESS+i; output j at START_ADDRESS+TOTAL_INPUTS+j; END = START_ADDRESS+TOTAL_INPUTS+TOTAL_OUTPUTS; hit iff START_ADDRESS <= address_i < END.
REQ-014 Opcodes: 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 RUN, 0x04 STREAM; other codes treated as NOP.
REQ-015 WRITE hitting an input register SHALL update it the next cycle; WRITE to an output address or a miss SHALL change no state.
REQ-016 READ hitting any mapped register SHALL load result_o the next cycle; result_o holds until next hitting READ; a miss leaves result_o unchanged.
REQ-017 hit_o SHALL be registered: set the cycle after a hitting non-NOP instruction, cleared the cycle after a missing one, held on NOP.
REQ-018 FSM states IDLE, RUN_WAIT, STREAM; RUN (address ignored) in IDLE SHALL pulse core_start_o for exactly one cycle and enter RUN_WAIT.
REQ-019 In RUN_WAIT, core_done_i SHALL latch all core_outputs_i into output registers and return to IDLE next cycle; core_done_i outside RUN_WAIT is ignored.
REQ-020 STREAM in IDLE SHALL present output registers 0..TOTAL_OUTPUTS-1 on stream_o on consecutive cycles starting the next cycle, stream_valid_o high throughout, stream_last_o with the final word, then IDLE; index wraps to 0 for the next STREAM.
REQ-021 While busy_o, WRITE, RUN and STREAM SHALL be ignored; READ SHALL still be served.
REQ-022 Output registers change only on core_done_i in RUN_WAIT; core_inputs_o is stable throughout RUN_WAIT.
REQ-023 Address compare SHALL use full ADDR_WIDTH; no wrap-around aliasing at END or at 2^ADDR_WIDTH.

Reset
REQ-024 rst_i SHALL, at the next edge and from any state, force IDLE and zero all registers, result_o, stream_o, stream_valid_o, stream_last_o, core_start_o, busy_o, hit_o.
REQ-025 An instruction coincident with rst_i SHALL be discarded.

Structure
REQ-026 Opcode constants and FSM state encodings SHALL reside in shared package titan_bus_pkg.
REQ-027 Window decode (hit flag, register index, input/output select) SHALL be sub-module titan_addr_decode, parametrised identically.
REQ-028 Elaboration SHALL fail if TOTAL_INPUTS or TOTAL_OUTPUTS is 0 or END exceeds 2^ADDR_WIDTH.

Verification
REQ-029 Defaults: WRITE 0x0000_0005 @0, WRITE 0x0000_0007 @1, READ @1 -> result_o=0x0000_0007 one cycle later, hit_o=1.
REQ-030 RUN -> core_start_o one-cycle pulse, busy_o=1; core_done_i with core_outputs_i=0x0000_000C -> READ @2 gives 0x0000_000C, busy_o=0.
REQ-031 TOTAL_OUTPUTS=3, outputs 0xA,0xB,0xC after RUN: STREAM -> stream_o 0xA,0xB,0xC on 3 consecutive cycles, stream_last_o only with 0xC; repeat STREAM restarts at 0xA.
REQ-032 WRITE 0x1234 @3 (miss) and WRITE @2 (output) -> no register change, result_o unchanged, hit_o=0 after the @3 miss.
REQ-033 In RUN_WAIT: WRITE 0x99 @0 ignored, READ @0 served; core_done_i while IDLE -> outputs unchanged.
REQ-034 rst_i asserted in RUN_WAIT and mid-STREAM -> next edge IDLE, all outputs 0; later core_done_i ignored.
